// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable latency
//
// Word-organised data RAM behind a valid/ready request channel and a valid/ready
// response channel. One transaction is in flight at a time.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..65536)
//   LATENCY      cycles from request acceptance to resp_valid (1..15)
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr,
//   req_wdata, req_wstrb            request payload (byte address, store data, byte enables)
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_error          response payload (load data, misaligned/out-of-range flag)

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          addr_err;
    logic [AW-1:0] widx;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    // Full 30-bit word index is compared so high address bits never alias onto the RAM.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign widx     = req_addr[AW+1:2];

    // RAM is deliberately not reset; a request coinciding with rst must not write.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_write && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        resp_error <= addr_err;
                        // Load data is sampled once here and frozen until the response handshake.
                        resp_rdata <= (!req_write && !addr_err) ? mem[widx] : 32'd0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Counter reaches zero on this edge, so the response goes out now.
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder

module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;

    logic        req_valid1, req_ready1, req_write1;
    logic [31:0] req_addr1, req_wdata1;
    logic [3:0]  req_wstrb1;
    logic        resp_valid1, resp_ready1, resp_error1;
    logic [31:0] resp_rdata1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_error(resp_error1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // One transaction on the LATENCY=2 instance; entered and left at a negedge.
    task automatic txn(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        logic [31:0] d0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(LAT));
        chk({name, "_rdata"}, resp_rdata, exp_rdata);
        chk({name, "_error"}, 32'(resp_error), 32'(exp_err));
        d0 = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({name, "_hold_rdata"}, resp_rdata, d0);
            chk({name, "_hold_reqrdy"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({name, "_ready_after"}, 32'(req_ready), 32'd1);
        chk({name, "_valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'h1357_0000 + 32'(k) * 32'h0101_0011;
    endfunction

    // Back-to-back stream on the LATENCY=1 instance with resp_ready tied high.
    task automatic b2b(input bit wr);
        int issued, got, idx, last;
        issued = 0; got = 0; idx = 0; last = -1;
        req_valid1 = 1'b1; req_write1 = wr; req_wstrb1 = 4'hF; resp_ready1 = 1'b1;
        while (got < 10 && idx < 100) begin
            if (resp_valid1) begin
                chk(wr ? "b2b_st_rdata" : "b2b_ld_rdata", resp_rdata1, wr ? 32'd0 : pat(got));
                chk("b2b_error", 32'(resp_error1), 32'd0);
                got++;
                last = idx;
            end
            if (req_ready1) begin
                if (issued < 10) begin
                    req_addr1  = 32'h40 + 32'(issued) * 4;
                    req_wdata1 = pat(issued);
                    issued++;
                end else begin
                    req_valid1 = 1'b0;
                end
            end
            @(negedge clk);
            idx++;
        end
        req_valid1 = 1'b0;
        chk(wr ? "b2b_st_cycles" : "b2b_ld_cycles", 32'(last + 1), 32'd20);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t tbl[15];

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];

    initial begin
        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'h0,   32'h12345678, 4'hF, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b1, 32'h30,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h30,  32'h00000000, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h30,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[12] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        tbl[14] = '{1'b0, 32'h80000000, 32'h0,   4'h0, 32'h0,        1'b1};

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
        req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; req_wstrb1 = 0; resp_ready1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_req_ready1", 32'(req_ready1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_req_ready1", 32'(req_ready1), 32'd1);

        for (int i = 0; i < 15; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0,
                tbl[i].rdata, tbl[i].err);
        end

        // Backpressure: response held 5 cycles.
        txn("bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0);

        // LATENCY=1 back-to-back stores then loads.
        b2b(1'b1);
        b2b(1'b0);

        // Reset while waiting on a store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_valid_wait", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_valid_in_rst", 32'(resp_valid), 32'd0);
        chk("rstw_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready_after", 32'(req_ready), 32'd1);
        chk("rstw_valid_after", 32'(resp_valid), 32'd0);
        // Request presented on a reset edge while ready: must not write.
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h99; req_wstrb = 4'hF;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rstreq_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("rstreq_valid2", 32'(resp_valid), 32'd0);
        txn("rst_load8", 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h00000055, 1'b0);

        // Randomized traffic against a word-array reference model (words 64..127).
        for (int t = 0; t < 40; t++) begin
            int          r, wi;
            bit          wr, e;
            logic [31:0] a, wd, mask, er;
            logic [3:0]  s;
            r  = $urandom_range(0, 9);
            wi = $urandom_range(64, 127);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            if (r == 0)      a = 32'(wi) * 4 + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 4000)) * 4;
            else             a = 32'(wi) * 4;
            e = (a % 4 != 0) || (a / 4 >= DEPTH);
            if (!e && !known[wi]) begin
                wr = 1'b1;
                s  = 4'hF;
            end
            er = 32'd0;
            if (!e && wr) begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                model[wi] = (model[wi] & ~mask) | (wd & mask);
                known[wi] = 1'b1;
            end else if (!e) begin
                er = model[wi];
            end
            txn($sformatf("rnd%0d", t), wr, a, wd, s, $urandom_range(0, 3), er, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data-memory responder serving the CPU's load/store request channel, with one outstanding transaction, programmable response latency and strict valid/ready handshakes on both the request and response channels. It holds the word-organised data RAM and sits between the CPU memory stage and the top level. It also lets the testbench exercise non-zero memory latency and CPU stalls without a full memory model.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..65536.
- LATENCY, 2: cycles from request acceptance to `resp_valid`; range 1..15.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-enable mask for stores; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  CPU accepts response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_error  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, capture the request and go to WAIT with latency counter = LATENCY-1.
  - If LATENCY=1, go directly to RESP.
- Error check at acceptance: `req_addr[1:0]!=0`, or word index `req_addr[31:2] >= DEPTH_WORDS` → `resp_error`=1.
  - Memory is not touched.
  - `resp_rdata`=0.
- Store without error: on the acceptance edge, write the bytes selected by `req_wstrb` to word `req_addr[31:2]`.
  - `wstrb`=0 is legal and writes nothing.
  - Response `rdata`=0, `error`=0.
- Load without error: read the addressed word on the acceptance edge into a data register. The value is frozen until the response handshake.
- WAIT:
  - Decrement the counter each cycle.
  - At 0, go to RESP.
  - `req_ready`=0.
- RESP:
  - `resp_valid`=1; `resp_rdata` and `resp_error` are stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - `req_ready`=0 throughout RESP, including the handshake cycle.
- Request inputs are ignored outside IDLE.
- Memory contents are not cleared by reset. Reads of never-written words return X in simulation.

## Timing
- Reset values:
  - `req_ready`=0 during reset, then 1 the cycle after `rst` deasserts (state IDLE).
  - `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
- Latency, with acceptance at edge N:
  - `resp_valid` rises in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later.
  - LATENCY=1 gives `resp_valid` in cycle N+1.
- Backpressure: with `resp_ready` low, `resp_valid`/`rdata`/`error` hold indefinitely with no change.
- Throughput: handshake at edge M → `req_ready`=1 in cycle M+1. Best case is one transaction per LATENCY+1 cycles.
- Reset mid-operation:
  - Any pending response is dropped and the FSM returns to IDLE.
  - A store already accepted before the reset edge remains written.
- Request accepted in the same cycle `rst`=1: ignored; no write.
- The word index uses `req_addr[31:2]` only. No wrap-around: an out-of-range index is always an error.

## Test plan
- LATENCY=2: store `addr`=0x10, `wdata`=0xDEADBEEF, `wstrb`=0xF; then load 0x10. Required:
  - Store response `rdata`=0, `error`=0.
  - Load response `rdata`=0xDEADBEEF.
  - `resp_valid` rises exactly 2 cycles after each acceptance.
- Byte strobes:
  - Store 0x11223344 to 0x20 with `wstrb`=0xF.
  - Then store 0xAABBCCDD with `wstrb`=0x5.
  - Load 0x20 → 0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned) → `error`=1, `rdata`=0.
  - Store 0x400 with DEPTH_WORDS=256 → `error`=1, and a following load of 0x0 is unchanged.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`. Required:
  - `resp_valid`/`rdata` stay stable.
  - `req_ready` stays 0.
  - Raise `resp_ready`: `req_ready`=1 the next cycle.
- LATENCY=1 back-to-back with `resp_ready` tied 1 and `req_valid` held high: 10 sequential loads complete in 20 cycles.
- Assert `rst` while in WAIT after a store of 0x55 to 0x8. Required:
  - `resp_valid` never asserts for that store.
  - `req_ready`=1 one cycle after reset release.
  - Load 0x8 → 0x00000055.
